// File: rtl/btb_update_queue.sv
// Buffers indirect-jump target mispredicts as BTB updates and coalesces repeats to the same PC.
// Latency: a push into an empty queue appears on btb_update_* one cycle later; mispredict_o is combinational.
// Backpressure: head is held until btb_ready_i; a full queue without a pop drops the update and counts it.
module btb_update_queue #(
   parameter int unsigned VLEN       = 64,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DROP_CNT_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     debug_mode_i,
   input  logic                     resolve_valid_i,
   input  logic                     resolve_is_indir_i,
   input  logic [VLEN-1:0]          resolve_pc_i,
   input  logic [VLEN-1:0]          resolve_target_i,
   input  logic                     pred_valid_i,
   input  logic [VLEN-1:0]          pred_target_i,
   output logic                     mispredict_o,
   output logic                     btb_update_valid_o,
   output logic [VLEN-1:0]          btb_update_pc_o,
   output logic [VLEN-1:0]          btb_update_target_o,
   input  logic                     btb_ready_i,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [VLEN-1:0]       pc_mem  [DEPTH];
   logic [VLEN-1:0]       tgt_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      newest_ptr;
   logic [OCC_W-1:0]      occ;
   logic [DROP_CNT_W-1:0] drop_cnt;

   logic push_req;
   logic pop;
   logic not_empty;
   logic is_full;
   logic coalesce;
   logic do_push;
   logic drop;

   // Mispredict detection, push/pop qualification and coalesce/drop decisions.
   always_comb begin
      mispredict_o = resolve_valid_i & resolve_is_indir_i &
                     (~pred_valid_i | (pred_target_i != resolve_target_i));
      push_req     = mispredict_o & ~debug_mode_i & ~flush_i;
      not_empty    = (occ != '0);
      is_full      = (occ == OCC_FULL);
      pop          = not_empty & btb_ready_i;
      newest_ptr   = wr_ptr - PTR_W'(1);
      // A lone entry leaving this cycle cannot absorb the new target; it gets its own slot.
      coalesce     = push_req & not_empty & (pc_mem[newest_ptr] == resolve_pc_i) &
                     ~((occ == OCC_W'(1)) & pop);
      do_push      = push_req & ~coalesce & (~is_full | pop);
      drop         = push_req & ~coalesce & is_full & ~pop;
   end

   // Entry storage: new entries at the tail, coalesced targets overwrite the newest entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]  <= '0;
            tgt_mem[i] <= '0;
         end
      end else if (do_push) begin
         pc_mem[wr_ptr]  <= resolve_pc_i;
         tgt_mem[wr_ptr] <= resolve_target_i;
      end else if (coalesce) begin
         tgt_mem[newest_ptr] <= resolve_target_i;
      end
   end

   // Pointers and occupancy; flush empties the queue after any head pop in the same cycle completes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !pop)      occ <= occ + OCC_W'(1);
         else if (pop && !do_push) occ <= occ - OCC_W'(1);
      end
   end

   // Saturating count of updates lost to a full queue; survives flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

   assign btb_update_valid_o  = not_empty;
   assign btb_update_pc_o     = pc_mem[rd_ptr];
   assign btb_update_target_o = tgt_mem[rd_ptr];
   assign occupancy_o         = occ;
   assign drop_cnt_o          = drop_cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: directed scenarios then random traffic against a queue-based model.
// Inputs change on the falling edge; outputs are compared 1ns later, before the next rising edge.
// Drop counter is narrowed to 4 bits so saturation is reached during random traffic.
module tb_btb_update_queue;

   localparam int unsigned VLEN  = 64;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 4;
   localparam int unsigned DMAX  = (1 << DW) - 1;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             flush_i, debug_mode_i;
   logic             resolve_valid_i, resolve_is_indir_i;
   logic [VLEN-1:0]  resolve_pc_i, resolve_target_i;
   logic             pred_valid_i;
   logic [VLEN-1:0]  pred_target_i;
   logic             mispredict_o, btb_update_valid_o;
   logic [VLEN-1:0]  btb_update_pc_o, btb_update_target_o;
   logic             btb_ready_i;
   logic [2:0]       occupancy_o;
   logic [DW-1:0]    drop_cnt_o;

   btb_update_queue #(.VLEN(VLEN), .DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
      .resolve_valid_i(resolve_valid_i), .resolve_is_indir_i(resolve_is_indir_i),
      .resolve_pc_i(resolve_pc_i), .resolve_target_i(resolve_target_i),
      .pred_valid_i(pred_valid_i), .pred_target_i(pred_target_i),
      .mispredict_o(mispredict_o), .btb_update_valid_o(btb_update_valid_o),
      .btb_update_pc_o(btb_update_pc_o), .btb_update_target_o(btb_update_target_o),
      .btb_ready_i(btb_ready_i), .occupancy_o(occupancy_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [63:0] pc; logic [63:0] tgt; } upd_t;
   upd_t mq[$];
   int   mdrop = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
   task automatic cyc(input logic rv, input logic ind, input logic [63:0] pc, input logic [63:0] tgt,
                      input logic pv, input logic [63:0] pt, input logic rdy, input logic dbg,
                      input logic fl);
      logic mp, push, pop;
      upd_t e;
      @(negedge clk_i);
      resolve_valid_i = rv; resolve_is_indir_i = ind; resolve_pc_i = pc; resolve_target_i = tgt;
      pred_valid_i = pv; pred_target_i = pt; btb_ready_i = rdy; debug_mode_i = dbg; flush_i = fl;
      #1;
      mp = rv && ind && (!pv || pt != tgt);
      check("mispredict", 64'(mispredict_o), 64'(mp));
      check("valid", 64'(btb_update_valid_o), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("head_pc", btb_update_pc_o, mq[0].pc);
         check("head_tgt", btb_update_target_o, mq[0].tgt);
      end
      check("occupancy", 64'(occupancy_o), 64'(mq.size()));
      check("drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
      push = mp && !dbg && !fl;
      pop  = (mq.size() != 0) && rdy;
      if (push && mq.size() != 0 && mq[$].pc == pc && !(mq.size() == 1 && pop)) begin
         mq[$].tgt = tgt;
         if (pop) void'(mq.pop_front());
      end else if (push) begin
         if (mq.size() < DEPTH || pop) begin
            if (pop) void'(mq.pop_front());
            e.pc = pc; e.tgt = tgt;
            mq.push_back(e);
         end else begin
            if (mdrop < DMAX) mdrop++;
         end
      end else if (pop) begin
         void'(mq.pop_front());
      end
      if (fl) mq.delete();
   endtask

   task automatic miss(input logic [63:0] pc, input logic [63:0] tgt, input logic rdy, input logic dbg);
      cyc(1'b1, 1'b1, pc, tgt, 1'b0, 64'h0, rdy, dbg, 1'b0);
   endtask

   task automatic idle(input logic rdy, input logic fl);
      cyc(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, rdy, 1'b0, fl);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(btb_update_valid_o), 64'h0);
      check({tag, "_pc"}, btb_update_pc_o, 64'h0);
      check({tag, "_tgt"}, btb_update_target_o, 64'h0);
      check({tag, "_occ"}, 64'(occupancy_o), 64'h0);
      check({tag, "_drop"}, 64'(drop_cnt_o), 64'h0);
   endtask

   initial begin
      logic [63:0] pc, tgt, pt;
      logic        rv, ind, pv, rdy, dbg, fl;
      rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; resolve_valid_i = 1'b0;
      resolve_is_indir_i = 1'b0; resolve_pc_i = '0; resolve_target_i = '0;
      pred_valid_i = 1'b0; pred_target_i = '0; btb_ready_i = 1'b0;
      #2;
      check_all_zero("reset");
      @(negedge clk_i); rst_ni = 1'b1;

      // Hit then target miss on the same indirect jump.
      cyc(1'b1, 1'b1, 64'h8000_0100, 64'h200, 1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 64'h8000_0100, 64'h240, 1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);

      // Coalescing of back-to-back updates to one PC.
      miss(64'h1000, 64'h2000, 1'b0, 1'b0);
      miss(64'h1000, 64'h3000, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      check("coalesce_occ", 64'(occupancy_o), 64'd1);
      check("coalesce_tgt", btb_update_target_o, 64'h3000);
      idle(1'b1, 1'b0);

      // Full queue: fifth distinct PC is dropped, then drain in order.
      for (int i = 0; i < 5; i++) miss(64'h4000 + 64'(i) * 16, 64'h9000 + 64'(i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 4; i++) miss(64'h6000 + 64'(i) * 16, 64'hA000 + 64'(i), 1'b0, 1'b0);
      miss(64'h5000, 64'hB000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);

      // Debug mode suppresses enqueue but not draining.
      for (int i = 0; i < 3; i++) miss(64'h7000 + 64'(i) * 16, 64'hC000 + 64'(i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) miss(64'h7800 + 64'(i) * 16, 64'hD000, 1'b1, 1'b1);

      // Flush with a head pop in the same cycle; the flush-cycle mispredict is not a drop.
      for (int i = 0; i < 3; i++) miss(64'h8000 + 64'(i) * 16, 64'hE000 + 64'(i), 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 64'h8800, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 1'b0);

      // Random traffic over a small PC set to exercise coalescing, drops and saturation.
      for (int n = 0; n < 3000; n++) begin
         rv  = ($urandom_range(0, 9) < 7);
         ind = ($urandom_range(0, 9) < 8);
         pc  = 64'h1000 + 64'($urandom_range(0, 3)) * 16;
         tgt = 64'h2000 + 64'($urandom_range(0, 3)) * 8;
         pv  = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0: pt = tgt;
            1: pt = tgt ^ 64'h8000_0000_0000_0000;
            default: pt = 64'h2000 + 64'($urandom_range(0, 3)) * 8;
         endcase
         rdy = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 3 : 7));
         dbg = ($urandom_range(0, 19) == 0);
         fl  = ($urandom_range(0, 49) == 0);
         cyc(rv, ind, pc, tgt, pv, pt, rdy, dbg, fl);
      end
      check("drop_saturated", 64'(drop_cnt_o), 64'(DMAX));

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 3; i++) miss(64'h9000 + 64'(i) * 16, 64'hF000 + 64'(i), 1'b0, 1'b0);
      idle(1'b1, 1'b0);
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check_all_zero("async_rst");
      mq.delete(); mdrop = 0;
      @(negedge clk_i); rst_ni = 1'b1;
      idle(1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
